reg_read_arbiter: RTL and testbench

Round-robin arbiter that shares the single 4:1 register-select mux (`the_mux_switch_2`, R0..R3 → `output_x`) between four read requesters. It drives the mux select lines `I9`/`I8`, tracks each issued read through the mux's registered latency, and returns the captured data to the requester that issued it. The block sits between the control units that need register operands and the mux, and is the only driver of the mux select.

---
 rtl/reg_read_arbiter_if.sv | 14 +
 rtl/reg_read_arbiter.sv | 61 ++++++
 tb/tb_reg_read_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_read_arbiter_if.sv
// reg_read_arbiter_if: request/grant, mux select and read-return signals between requesters, the mux and the arbiter
interface reg_read_arbiter_if #(parameter int DATA_W = 8);
  logic [3:0] req;
  logic [7:0] req_addr;
  logic [3:0] gnt;
  logic I9;
  logic I8;
  logic [DATA_W-1:0] mux_data;
  logic [3:0] rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic busy;
  modport master (output req, req_addr, mux_data, input gnt, I9, I8, rd_valid, rd_data, busy);
  modport slave (input req, req_addr, mux_data, output gnt, I9, I8, rd_valid, rd_data, busy);
endinterface

// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: round-robin sharing of the 4:1 register mux, with a tag pipeline that routes captured data back to the requester
module reg_read_arbiter #(
  parameter int DATA_W = 8,
  parameter int MUX_LAT = 1
) (
  input logic sys_clk,
  input logic sys_rst,
  reg_read_arbiter_if.slave bus
);
  logic [1:0] ptr;
  logic [1:0] gnt_id;
  logic [1:0] pick;
  logic [1:0] idx;
  logic found;
  logic [3:0] elig;
  logic [MUX_LAT-1:0] tag_v;
  logic [1:0] tag_id [MUX_LAT];
  // the current grant is masked so a held request cannot win two cycles in a row
  always_comb begin
    elig = bus.req & ~bus.gnt;
    found = 1'b0;
    pick = ptr;
    idx = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  // tags enter one cycle after the grant so the tail lines up with valid mux output
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.gnt <= 4'b0;
      gnt_id <= 2'b0;
      ptr <= 2'b0;
      {bus.I9, bus.I8} <= 2'b0;
      tag_v <= '0;
      for (int i = 0; i < MUX_LAT; i++) tag_id[i] <= 2'b0;
      bus.rd_valid <= 4'b0;
      bus.rd_data <= '0;
    end else begin
      bus.gnt <= found ? 4'b0001 << pick : 4'b0;
      if (found) begin
        gnt_id <= pick;
        ptr <= pick + 2'd1;
        {bus.I9, bus.I8} <= bus.req_addr[2*pick +: 2];
      end
      tag_v[0] <= |bus.gnt;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < MUX_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      bus.rd_valid <= tag_v[MUX_LAT-1] ? 4'b0001 << tag_id[MUX_LAT-1] : 4'b0;
      if (tag_v[MUX_LAT-1]) bus.rd_data <= bus.mux_data;
    end
  end
  assign bus.busy = |tag_v || |bus.rd_valid;
endmodule

// File: tb/tb_reg_read_arbiter.sv
// tb_reg_read_arbiter: drives MUX_LAT=1 and MUX_LAT=3 builds side by side against a cycle-level reference model
module tb_reg_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = 4'h0;
  logic [7:0] addr = 8'h0;
  always #5 clk = ~clk;

  reg_read_arbiter_if #(.DATA_W(8)) bus1 ();
  reg_read_arbiter_if #(.DATA_W(8)) bus3 ();
  reg_read_arbiter #(.DATA_W(8), .MUX_LAT(1)) dut1 (.sys_clk(clk), .sys_rst(rst), .bus(bus1));
  reg_read_arbiter #(.DATA_W(8), .MUX_LAT(3)) dut3 (.sys_clk(clk), .sys_rst(rst), .bus(bus3));
  assign bus1.req = req;
  assign bus3.req = req;
  assign bus1.req_addr = addr;
  assign bus3.req_addr = addr;

  logic [7:0] regs [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] mp1 [1];
  logic [7:0] mp3 [3];
  always @(posedge clk) begin
    mp1[0] <= regs[{bus1.I9, bus1.I8}];
    mp3[0] <= regs[{bus3.I9, bus3.I8}];
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign bus1.mux_data = mp1[0];
  assign bus3.mux_data = mp3[2];

  logic [3:0] rv [2];
  logic [7:0] rd [2];
  logic bz [2];
  assign rv[0] = bus1.rd_valid;
  assign rv[1] = bus3.rd_valid;
  assign rd[0] = bus1.rd_data;
  assign rd[1] = bus3.rd_data;
  assign bz[0] = bus1.busy;
  assign bz[1] = bus3.busy;

  typedef struct {int due; int id; logic [7:0] data;} ret_t;
  ret_t q [2][$];
  int lat [2] = '{1, 3};
  logic [7:0] ed [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [3:0] m_gnt;
  int m_ptr;
  logic [1:0] m_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model();
    cyc++;
    if (rst) begin
      m_gnt = 4'h0;
      m_ptr = 0;
      m_sel = 2'b0;
      for (int j = 0; j < 2; j++) begin
        q[j].delete();
        ed[j] = 8'h0;
      end
    end else begin
      logic [3:0] e;
      int w;
      e = req & ~m_gnt;
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && e[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      m_gnt = 4'h0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_sel = addr[2*w +: 2];
        m_ptr = (w + 1) % 4;
        for (int j = 0; j < 2; j++) q[j].push_back('{cyc + lat[j] + 1, w, regs[m_sel]});
      end
    end
  endtask

  task automatic compare();
    check("gnt_l1", 32'(bus1.gnt), 32'(m_gnt));
    check("gnt_l3", 32'(bus3.gnt), 32'(m_gnt));
    check("sel_l1", 32'({bus1.I9, bus1.I8}), 32'(m_sel));
    check("sel_l3", 32'({bus3.I9, bus3.I8}), 32'(m_sel));
    for (int j = 0; j < 2; j++) begin
      logic b;
      logic [3:0] ev;
      b = 1'b0;
      ev = 4'h0;
      foreach (q[j][n]) if (q[j][n].due - lat[j] - 1 < cyc && q[j][n].due >= cyc) b = 1'b1;
      if (q[j].size() > 0 && q[j][0].due == cyc) begin
        ev = 4'b0001 << q[j][0].id;
        ed[j] = q[j][0].data;
        void'(q[j].pop_front());
      end
      check(j == 0 ? "rd_valid_l1" : "rd_valid_l3", 32'(rv[j]), 32'(ev));
      check(j == 0 ? "rd_data_l1" : "rd_data_l3", 32'(rd[j]), 32'(ed[j]));
      check(j == 0 ? "busy_l1" : "busy_l3", 32'(bz[j]), 32'(b));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  task automatic drop_granted();
    req = req & ~m_gnt;
  endtask

  initial begin
    logic prev;
    rst = 1'b1;
    req = 4'hF;
    addr = 8'hE4;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_release_gnt", 32'(bus1.gnt), 32'h1);
    rst = 1'b1;
    req = 4'h0;
    step();
    rst = 1'b0;
    req = 4'b0100;
    addr = 8'h30;
    for (int n = 0; n < 8; n++) begin
      step();
      if (n == 0) check("single_gnt", 32'(bus1.gnt), 32'h4);
      if (n == 2) check("single_rd_l1", 32'({bus1.rd_valid, bus1.rd_data}), 32'h413);
      if (n == 4) check("single_rd_l3", 32'({bus3.rd_valid, bus3.rd_data}), 32'h413);
      drop_granted();
    end
    req = 4'hF;
    addr = 8'hE4;
    repeat (14) step();
    req = 4'h0;
    repeat (6) step();
    req = 4'b0010;
    prev = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      check("b2b_mask", 32'(bus1.gnt[1] & prev), 32'h0);
      prev = bus1.gnt[1];
    end
    req = 4'h0;
    repeat (6) step();
    req = 4'b0001;
    addr = 8'h02;
    begin
      int guard;
      guard = 0;
      while (m_gnt == 4'h0 && guard < 10) begin
        step();
        guard++;
      end
      if (m_gnt == 4'h0) check("midflight_grant_timeout", 32'h0, 32'h1);
    end
    req = 4'h0;
    step();
    rst = 1'b1;
    step();
    check("midflight_busy", 32'({bus1.busy, bus3.busy}), 32'h0);
    check("midflight_sel", 32'({bus1.I9, bus1.I8, bus3.I9, bus3.I8}), 32'h0);
    rst = 1'b0;
    repeat (6) step();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99, 0) == 0);
      step();
      for (int i = 0; i < 4; i++) begin
        if (m_gnt[i] && $urandom_range(1, 0) == 1) req[i] = 1'b0;
        if (m_gnt[i] || !req[i]) addr[2*i +: 2] = 2'($urandom_range(3, 0));
        if (!req[i] && $urandom_range(2, 0) == 0) req[i] = 1'b1;
      end
    end
    rst = 1'b0;
    req = 4'h0;
    repeat (8) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
